// File: rtl/mul_div_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: data width,
// operation latencies, FSM state encoding and WriteEnable bit positions.
package mul_div_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned MUL_LATENCY_DEF = 4;
  // 1 setup + 32 iterations + 1 sign-fix.
  localparam int unsigned DIV_LATENCY     = 34;
  localparam int unsigned DIV_ITERS       = DIV_LATENCY - 2;

  localparam int unsigned WE_HI = 1;
  localparam int unsigned WE_LO = 0;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_SETUP,
    DIV_ITER,
    DIV_FIX
  } state_t;

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              en);
    return en ? DATA_W'(-v) : v;
  endfunction

endpackage

// File: rtl/mul_div_core_seq_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per step.
// Ports:
//   Clk, Clr           clock, async active-high clear
//   load               capture dividend/divisor, clear partial remainder
//   step               perform one shift-subtract iteration
//   dividend, divisor  unsigned operands (sampled on load)
//   quotient           quotient after DATA_W steps
//   remainder          remainder after DATA_W steps
module seq_divider
  import mul_div_pkg::*;
(
  input  logic              Clk,
  input  logic              Clr,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W:0]   shifted;
  logic              fits;
  logic [DATA_W-1:0] diff;

  // 33-bit partial remainder: previous remainder with the next dividend bit
  // shifted in. The quotient register doubles as the dividend shift source.
  assign shifted = {remainder, quotient[DATA_W-1]};
  assign fits    = (shifted >= {1'b0, dvs_q});
  // Remainder is always below the divisor, so the difference fits DATA_W bits.
  assign diff    = DATA_W'(shifted - {1'b0, dvs_q});

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      quotient  <= '0;
      remainder <= '0;
      dvs_q     <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs_q     <= divisor;
    end else if (step) begin
      quotient  <= {quotient[DATA_W-2:0], fits};
      remainder <= fits ? diff : shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/mul_div_core.sv
// MIPS execute-stage multiply/divide unit owning the HI/LO registers.
// Multiply takes MUL_LATENCY cycles, divide takes DIV_LATENCY cycles;
// HI/LO update only on the edge where Busy falls.
// Ports:
//   Clk, Clr      clock, async active-high reset
//   A, B          operands; A is also the MTHI/MTLO data
//   start         launch operation (ignored while Busy)
//   op_div        1 = divide, 0 = multiply
//   sign          1 = signed, 0 = unsigned
//   WriteEnable   [WE_HI] write HI from A, [WE_LO] write LO from A (idle only)
//   HI, LO        architectural result registers
//   Busy          operation in flight
module mul_div_core
  import mul_div_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              start,
  input  logic              op_div,
  input  logic              sign,
  input  logic [1:0]        WriteEnable,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              Busy
);

  localparam int unsigned CNT_MAX = (MUL_LATENCY > DIV_ITERS) ? MUL_LATENCY : DIV_ITERS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned PROD_W  = 2 * DATA_W;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic              sign_q;
  logic              q_neg_q, r_neg_q, zero_q;

  logic [DATA_W-1:0] hi_d, lo_d;
  logic              busy_d;
  logic              op_load, div_load, div_step;

  logic [PROD_W-1:0] mul_a, mul_b, prod;
  logic [DATA_W-1:0] div_quo, div_rem;
  logic [DATA_W-1:0] div_a, div_b;
  logic [DATA_W-1:0] q_fix, r_fix;

  // Multiply: extend both latched operands to 64 bits; the low 64 bits of the
  // product are correct for both signed and unsigned interpretations.
  assign mul_a = {{DATA_W{sign_q & a_q[DATA_W-1]}}, a_q};
  assign mul_b = {{DATA_W{sign_q & b_q[DATA_W-1]}}, b_q};
  assign prod  = mul_a * mul_b;

  // Divide: the iterative datapath only sees magnitudes.
  assign div_a = cond_neg(a_q, sign_q & a_q[DATA_W-1]);
  assign div_b = cond_neg(b_q, sign_q & b_q[DATA_W-1]);
  assign q_fix = cond_neg(div_quo, q_neg_q);
  assign r_fix = cond_neg(div_rem, r_neg_q);

  seq_divider u_div (
    .Clk       (Clk),
    .Clr       (Clr),
    .load      (div_load),
    .step      (div_step),
    .dividend  (div_a),
    .divisor   (div_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // State register.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = op_div ? DIV_SETUP : MUL;
      MUL:       if (cnt_q == CNT_W'(MUL_LATENCY - 1)) state_d = IDLE;
      DIV_SETUP: state_d = DIV_ITER;
      DIV_ITER:  if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = DIV_FIX;
      DIV_FIX:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath control. HI/LO change only on MT writes or the final
  // cycle of an operation; start takes priority over a same-cycle MT write.
  always_comb begin
    hi_d     = HI;
    lo_d     = LO;
    cnt_d    = cnt_q;
    op_load  = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          op_load = 1'b1;
        end else begin
          if (WriteEnable[WE_HI]) hi_d = A;
          if (WriteEnable[WE_LO]) lo_d = A;
        end
      end
      MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d == IDLE) begin
          hi_d = prod[PROD_W-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end
      end
      DIV_SETUP: begin
        div_load = 1'b1;
        cnt_d    = '0;
      end
      DIV_ITER: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      DIV_FIX: begin
        // Divide by zero returns the raw dividend in HI and all-ones in LO.
        hi_d = zero_q ? a_q : r_fix;
        lo_d = zero_q ? '1  : q_fix;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Working registers and architectural outputs.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      Busy    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      HI    <= hi_d;
      LO    <= lo_d;
      Busy  <= busy_d;
      if (op_load) begin
        a_q    <= A;
        b_q    <= B;
        sign_q <= sign;
      end
      if (div_load) begin
        q_neg_q <= sign_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        r_neg_q <= sign_q & a_q[DATA_W-1];
        zero_q  <= (b_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_mul_div_core.sv
// Directed self-checking bench for mul_div_core.
module tb_mul_div_core;

  logic        Clk;
  logic        Clr;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        op_div;
  logic        sign;
  logic [1:0]  WriteEnable;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;

  int passed = 0;
  int total  = 0;

  mul_div_core #(.MUL_LATENCY(4)) dut (
    .Clk         (Clk),
    .Clr         (Clr),
    .A           (A),
    .B           (B),
    .start       (start),
    .op_div      (op_div),
    .sign        (sign),
    .WriteEnable (WriteEnable),
    .HI          (HI),
    .LO          (LO),
    .Busy        (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Launch one operation from a negedge; return Busy-high cycle count and
  // whether HI/LO stayed frozen while Busy. Operands are scrambled after the
  // start edge so the DUT must use its latched copies.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic d,
                        output int cyc, output logic stable);
    logic [31:0] h0, l0;
    h0 = HI; l0 = LO; stable = 1'b1;
    A = a; B = b; sign = s; op_div = d; WriteEnable = 2'b00; start = 1'b1;
    @(negedge Clk);
    start = 1'b0; A = 32'hA5A5A5A5; B = 32'h0; sign = ~s;
    cyc = 0;
    while (Busy && cyc < 100) begin
      if (HI !== h0 || LO !== l0) stable = 1'b0;
      cyc++;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    total++; if (HI !== 32'h0) $display("FAIL rst_hi got %h exp %h", HI, 32'h0); else passed++;
    total++; if (LO !== 32'h0) $display("FAIL rst_lo got %h exp %h", LO, 32'h0); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", Busy); else passed++;
    Clr = 1'b0;
    WriteEnable = 2'b11; A = 32'h11111111;
    @(negedge Clk);
    WriteEnable = 2'b00;
    total++; if (HI !== 32'h11111111) $display("FAIL mt_both_hi got %h exp %h", HI, 32'h11111111); else passed++;
    total++; if (LO !== 32'h11111111) $display("FAIL mt_both_lo got %h exp %h", LO, 32'h11111111); else passed++;
    // Async clear mid-cycle while a multiply is in flight.
    A = 32'd3; B = 32'd5; sign = 1'b0; op_div = 1'b0; start = 1'b1;
    @(posedge Clk);
    #2;
    start = 1'b0;
    total++; if (Busy !== 1'b1) $display("FAIL pre_clr_busy got %b exp 1", Busy); else passed++;
    Clr = 1'b1;
    #1;
    total++; if (HI !== 32'h0) $display("FAIL async_hi got %h exp %h", HI, 32'h0); else passed++;
    total++; if (LO !== 32'h0) $display("FAIL async_lo got %h exp %h", LO, 32'h0); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL async_busy got %b exp 0", Busy); else passed++;
    @(negedge Clk);
    Clr = 1'b0;
  endtask

  task automatic test_mul();
    int cyc; logic st;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, cyc, st);
    total++; if (HI !== 32'hFFFFFFFE) $display("FAIL multu_hi got %h exp %h", HI, 32'hFFFFFFFE); else passed++;
    total++; if (LO !== 32'h00000001) $display("FAIL multu_lo got %h exp %h", LO, 32'h00000001); else passed++;
    total++; if (cyc != 4) $display("FAIL multu_cycles got %0d exp 4", cyc); else passed++;
    total++; if (st !== 1'b1) $display("FAIL multu_hold got %b exp 1", st); else passed++;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, cyc, st);
    total++; if (HI !== 32'h00000000) $display("FAIL mult_hi got %h exp %h", HI, 32'h0); else passed++;
    total++; if (LO !== 32'h00000001) $display("FAIL mult_lo got %h exp %h", LO, 32'h1); else passed++;
    total++; if (cyc != 4) $display("FAIL mult_cycles got %0d exp 4", cyc); else passed++;
    total++; if (st !== 1'b1) $display("FAIL mult_hold got %b exp 1", st); else passed++;
    run_op(32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, cyc, st);
    total++; if (HI !== 32'hFFFFFFFF) $display("FAIL mult_neg_hi got %h exp %h", HI, 32'hFFFFFFFF); else passed++;
    total++; if (LO !== 32'hFFFFFFFA) $display("FAIL mult_neg_lo got %h exp %h", LO, 32'hFFFFFFFA); else passed++;
  endtask

  task automatic test_div();
    int cyc; logic st;
    run_op(32'd100, 32'd7, 1'b0, 1'b1, cyc, st);
    total++; if (LO !== 32'd14) $display("FAIL divu_lo got %h exp %h", LO, 32'd14); else passed++;
    total++; if (HI !== 32'd2) $display("FAIL divu_hi got %h exp %h", HI, 32'd2); else passed++;
    total++; if (cyc != 34) $display("FAIL divu_cycles got %0d exp 34", cyc); else passed++;
    total++; if (st !== 1'b1) $display("FAIL divu_hold got %b exp 1", st); else passed++;
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, cyc, st);
    total++; if (LO !== 32'hFFFFFFFD) $display("FAIL div_m7_2_lo got %h exp %h", LO, 32'hFFFFFFFD); else passed++;
    total++; if (HI !== 32'hFFFFFFFF) $display("FAIL div_m7_2_hi got %h exp %h", HI, 32'hFFFFFFFF); else passed++;
    total++; if (cyc != 34) $display("FAIL div_s_cycles got %0d exp 34", cyc); else passed++;
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, cyc, st);
    total++; if (LO !== 32'hFFFFFFFD) $display("FAIL div_7_m2_lo got %h exp %h", LO, 32'hFFFFFFFD); else passed++;
    total++; if (HI !== 32'h00000001) $display("FAIL div_7_m2_hi got %h exp %h", HI, 32'h1); else passed++;
  endtask

  task automatic test_corner();
    int cyc; logic st;
    run_op(32'h12345678, 32'h0, 1'b0, 1'b1, cyc, st);
    total++; if (HI !== 32'h12345678) $display("FAIL dz_u_hi got %h exp %h", HI, 32'h12345678); else passed++;
    total++; if (LO !== 32'hFFFFFFFF) $display("FAIL dz_u_lo got %h exp %h", LO, 32'hFFFFFFFF); else passed++;
    total++; if (cyc != 34) $display("FAIL dz_cycles got %0d exp 34", cyc); else passed++;
    run_op(32'h80000001, 32'h0, 1'b1, 1'b1, cyc, st);
    total++; if (HI !== 32'h80000001) $display("FAIL dz_s_hi got %h exp %h", HI, 32'h80000001); else passed++;
    total++; if (LO !== 32'hFFFFFFFF) $display("FAIL dz_s_lo got %h exp %h", LO, 32'hFFFFFFFF); else passed++;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, cyc, st);
    total++; if (LO !== 32'h80000000) $display("FAIL ovf_lo got %h exp %h", LO, 32'h80000000); else passed++;
    total++; if (HI !== 32'h00000000) $display("FAIL ovf_hi got %h exp %h", HI, 32'h0); else passed++;
  endtask

  task automatic test_mthi_mtlo();
    int cyc;
    logic [31:0] lo0;
    lo0 = LO;
    WriteEnable = 2'b10; A = 32'hDEADBEEF;
    @(negedge Clk);
    WriteEnable = 2'b00;
    total++; if (HI !== 32'hDEADBEEF) $display("FAIL mthi_hi got %h exp %h", HI, 32'hDEADBEEF); else passed++;
    total++; if (LO !== lo0) $display("FAIL mthi_lo got %h exp %h", LO, lo0); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL mthi_busy got %b exp 0", Busy); else passed++;
    WriteEnable = 2'b01; A = 32'hCAFEF00D;
    @(negedge Clk);
    WriteEnable = 2'b00;
    total++; if (LO !== 32'hCAFEF00D) $display("FAIL mtlo_lo got %h exp %h", LO, 32'hCAFEF00D); else passed++;
    total++; if (HI !== 32'hDEADBEEF) $display("FAIL mtlo_hi got %h exp %h", HI, 32'hDEADBEEF); else passed++;
    // MT write during a divide is ignored.
    A = 32'd100; B = 32'd7; sign = 1'b0; op_div = 1'b1; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (3) @(negedge Clk);
    WriteEnable = 2'b11; A = 32'hDEADDEAD;
    @(negedge Clk);
    WriteEnable = 2'b00;
    total++; if (HI !== 32'hDEADBEEF) $display("FAIL mt_busy_hi got %h exp %h", HI, 32'hDEADBEEF); else passed++;
    total++; if (LO !== 32'hCAFEF00D) $display("FAIL mt_busy_lo got %h exp %h", LO, 32'hCAFEF00D); else passed++;
    cyc = 0;
    while (Busy && cyc < 100) begin cyc++; @(negedge Clk); end
    total++; if (LO !== 32'd14) $display("FAIL mt_busy_res_lo got %h exp %h", LO, 32'd14); else passed++;
    total++; if (HI !== 32'd2) $display("FAIL mt_busy_res_hi got %h exp %h", HI, 32'd2); else passed++;
    // start plus WriteEnable in the same cycle: write dropped.
    A = 32'd3; B = 32'd5; sign = 1'b0; op_div = 1'b0; start = 1'b1; WriteEnable = 2'b11;
    @(negedge Clk);
    start = 1'b0; WriteEnable = 2'b00;
    total++; if (HI !== 32'd2) $display("FAIL st_we_hi got %h exp %h", HI, 32'd2); else passed++;
    total++; if (LO !== 32'd14) $display("FAIL st_we_lo got %h exp %h", LO, 32'd14); else passed++;
    total++; if (Busy !== 1'b1) $display("FAIL st_we_busy got %b exp 1", Busy); else passed++;
    cyc = 0;
    while (Busy && cyc < 100) begin cyc++; @(negedge Clk); end
    total++; if (LO !== 32'd15) $display("FAIL st_we_res_lo got %h exp %h", LO, 32'd15); else passed++;
    total++; if (HI !== 32'd0) $display("FAIL st_we_res_hi got %h exp %h", HI, 32'd0); else passed++;
  endtask

  task automatic test_abort();
    int cyc; logic st;
    A = 32'd100; B = 32'd7; sign = 1'b0; op_div = 1'b1; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    total++; if (Busy !== 1'b1) $display("FAIL abort_pre_busy got %b exp 1", Busy); else passed++;
    Clr = 1'b1;
    #1;
    total++; if (Busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", Busy); else passed++;
    total++; if (HI !== 32'h0) $display("FAIL abort_hi got %h exp %h", HI, 32'h0); else passed++;
    total++; if (LO !== 32'h0) $display("FAIL abort_lo got %h exp %h", LO, 32'h0); else passed++;
    @(negedge Clk);
    Clr = 1'b0;
    run_op(32'd6, 32'd3, 1'b0, 1'b1, cyc, st);
    total++; if (LO !== 32'd2) $display("FAIL post_abort_lo got %h exp %h", LO, 32'd2); else passed++;
    total++; if (HI !== 32'd0) $display("FAIL post_abort_hi got %h exp %h", HI, 32'd0); else passed++;
    total++; if (cyc != 34) $display("FAIL post_abort_cycles got %0d exp 34", cyc); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    A = 32'd100; B = 32'd7; sign = 1'b0; op_div = 1'b1; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    cyc = 0;
    while (Busy && cyc < 100) begin
      cyc++;
      start = (cyc == 5);
      if (cyc == 5) begin
        A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; sign = 1'b1; op_div = 1'b0;
      end
      @(negedge Clk);
    end
    start = 1'b0;
    total++; if (cyc != 34) $display("FAIL overlap_cycles got %0d exp 34", cyc); else passed++;
    total++; if (LO !== 32'd14) $display("FAIL overlap_lo got %h exp %h", LO, 32'd14); else passed++;
    total++; if (HI !== 32'd2) $display("FAIL overlap_hi got %h exp %h", HI, 32'd2); else passed++;
    @(negedge Clk);
    total++; if (Busy !== 1'b0) $display("FAIL overlap_idle got %b exp 0", Busy); else passed++;
  endtask

  initial begin
    Clr = 1'b1; A = '0; B = '0; start = 1'b0; op_div = 1'b0; sign = 1'b0; WriteEnable = 2'b00;
    repeat (2) @(negedge Clk);
    test_reset();
    test_mul();
    test_div();
    test_corner();
    test_mthi_mtlo();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mul_div_core.md
Name: mul_div_core

Overview:
- Integer multiply/divide unit for the MIPS execute stage. Owns the HI/LO architectural registers.
- Multiply is multi-cycle (MULT/MULTU/MUL). Divide is a sequential radix-2 divider (DIV/DIVU).
- Also accepts direct HI/LO writes (MTHI/MTLO).
- The pipeline stalls on Busy and reads HI/LO once Busy is low.

Parameters:
- MUL_LATENCY, default 4: cycles Busy stays high for a multiply (≥1).
- DIV_LATENCY, fixed at 34: 1 setup cycle, 32 iteration cycles, 1 sign-fix cycle. Not overridable.

Ports:
- Clk  in  1  system clock, rising edge.
- Clr  in  1  reset, asynchronous, active-high.
- A  in  32  operand A: multiplicand / dividend / MTHI-MTLO data.
- B  in  32  operand B: multiplier / divisor.
- start  in  1  launch an operation, sampled at posedge.
- op_div  in  1  1 = divide, 0 = multiply; qualified by start.
- sign  in  1  1 = signed (MULT/MUL/DIV), 0 = unsigned.
- WriteEnable  in  2  bit1 = write HI from A, bit0 = write LO from A.
- HI  out  32  HI register (remainder / upper product).
- LO  out  32  LO register (quotient / lower product).
- Busy  out  1  operation in flight, registered.

Behaviour:
- Reset (Clr=1, async): HI=0, LO=0, Busy=0, FSM=IDLE, all working registers cleared. Reset mid-operation aborts it with no write-back.
- FSM states:
  - IDLE -> MUL on start & !op_div & !Busy.
  - IDLE -> DIV_SETUP on start & op_div & !Busy.
  - MUL -> IDLE after MUL_LATENCY cycles.
  - DIV_SETUP -> DIV_ITER (32 cycles) -> DIV_FIX -> IDLE.
- Busy timing: Busy rises on the posedge that samples start. It stays high exactly MUL_LATENCY (multiply) or 34 (divide) cycles. It falls on the same posedge that loads HI/LO.
- HI/LO are separate from the working registers. They hold their old values throughout an operation; no intermediate values ever appear on them.
- start while Busy=1 is ignored.
- WriteEnable while Busy=1 is ignored.
- start and nonzero WriteEnable in the same cycle: start wins, the write is dropped.
- MTHI/MTLO when idle: the selected register takes A at the next posedge; the other register is unchanged. WriteEnable=2'b11 writes A to both. Busy stays 0.
- Multiply: 64-bit product of A×B. Two's-complement when sign=1, unsigned otherwise. HI = product[63:32], LO = product[31:0]. Internal structure is free (e.g. pipelined DSP multiply plus delay chain), provided latency is exact.
- Divide, DIV_SETUP: latch magnitudes |A| and |B| when sign=1 (raw values otherwise). Record quotient sign = A[31]^B[31] and remainder sign = A[31].
- Divide, DIV_ITER: restoring or non-restoring shift-subtract, one quotient bit per cycle, 33-bit partial remainder.
- Divide, DIV_FIX: negate quotient/remainder per the recorded signs. LO = quotient, HI = remainder. The remainder takes the sign of the dividend; the quotient truncates toward zero.
- Divisor zero (signed or unsigned): HI=A, LO=0xFFFFFFFF, full 34-cycle latency.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no exception.

Decomposition:
- Shared package mul_div_pkg holds:
  - DIV_LATENCY=34 and the default MUL_LATENCY;
  - the FSM state enum (IDLE, MUL, DIV_SETUP, DIV_ITER, DIV_FIX);
  - WriteEnable bit positions (WE_HI=1, WE_LO=0).
- One natural sub-module: seq_divider. It implements the 32-iteration unsigned shift-subtract datapath with a load/step interface and quotient/remainder outputs.
- Sign handling, the multiplier, the FSM and HI/LO stay in mul_div_core.

Test Plan:
- Reset: assert Clr mid-cycle -> HI=0, LO=0, Busy=0 immediately (asynchronously).
- Multiply, A=B=0xFFFFFFFF:
  - sign=0 -> HI=0xFFFFFFFE, LO=0x00000001.
  - sign=1 -> HI=0x00000000, LO=0x00000001.
  - Busy high exactly 4 cycles in both cases; HI/LO unchanged while Busy.
- Divide:
  - Unsigned 100/7 -> LO=14, HI=2, Busy high 34 cycles.
  - Signed -7/2 (0xFFFFFFF9/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Signed 7/-2 -> LO=0xFFFFFFFD, HI=0x00000001.
- Corner divides:
  - 0x12345678/0 -> HI=0x12345678, LO=0xFFFFFFFF.
  - Signed 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI/MTLO:
  - WriteEnable=2'b10, A=0xDEADBEEF when idle -> HI=0xDEADBEEF next cycle, LO unchanged.
  - Same stimulus during a divide -> ignored.
  - start with WriteEnable in the same cycle -> write dropped.
- Abort and overlap:
  - Clr pulse at cycle 10 of a divide -> Busy=0, HI=LO=0; a following 6/3 divide yields LO=2, HI=0.
  - start during Busy -> ignored, original result intact.
